// File: rtl/kanata_event_tracer.sv
// Kanata-style trace capture: snapshots per-stage acks, retires and flushes, streams one record per beat.
// Latency: capture in cycle T -> first record valid in T+2; consecutive snapshots drain without bubbles.
// Backpressure: m_tready low holds the record; snapshots beyond DEPTH are dropped (overflow, drop_cnt).
// Optional macro KANATA_TRACER_CYCLE_REC_EN adds a CYCLE record carrying the stamp delta per snapshot.

module kanata_snap_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push_vld,
    input  logic [WIDTH-1:0]       push_dat,
    output logic                   pop_vld,
    input  logic                   pop_rdy,
    output logic [WIDTH-1:0]       pop_dat,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push_do;
    logic             pop_do;

    assign level   = wr_ptr - rd_ptr;
    assign pop_vld = (level != '0);
    assign pop_do  = pop_vld && pop_rdy;
    assign push_do = push_vld && ((level != FULL_LVL) || pop_do);
    assign pop_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_do) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_do)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push_do) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

module kanata_event_tracer #(
    parameter int NUM_STAGES = 7,
    parameter int ID_WIDTH   = 64,
    parameter int DEPTH      = 8,
    parameter int MAX_FLUSH  = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           trace_en,
    input  logic [NUM_STAGES-1:0]          stage_ack,
    input  logic [NUM_STAGES*ID_WIDTH-1:0] stage_id,
    input  logic                           retire_ack,
    input  logic [ID_WIDTH-1:0]            retire_id,
    input  logic                           flush_valid,
    input  logic [ID_WIDTH-1:0]            flush_lo_id,
    input  logic [ID_WIDTH-1:0]            flush_hi_id,
    output logic                           m_tvalid,
    input  logic                           m_tready,
    output logic [3+8+ID_WIDTH+32-1:0]     m_tdata,
    output logic                           overflow,
    output logic [15:0]                    drop_cnt
);
    localparam int AW  = $clog2(DEPTH);
    localparam int FCW = $clog2(MAX_FLUSH + 1);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [NUM_STAGES-1:0]          ack;
        logic [NUM_STAGES*ID_WIDTH-1:0] ids;
        logic                           retire;
        logic [ID_WIDTH-1:0]            retire_id;
        logic [31:0]                    retire_seq;
        logic [ID_WIDTH-1:0]            flush_first;
        logic [FCW-1:0]                 flush_cnt;
`ifdef KANATA_TRACER_CYCLE_REC_EN
        logic [31:0]                    stamp;
`endif
    } snap_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STAGE,
        S_RETIRE,
        S_FLUSH
`ifdef KANATA_TRACER_CYCLE_REC_EN
        , S_CYCLE
`endif
    } state_t;

    state_t              state;
    state_t              next_state;
    state_t              adv_state;
    state_t              head_first;
    snap_t               cap;
    snap_t               head;
    snap_t               work;
    logic [$bits(snap_t)-1:0] head_dat;
    logic                head_vld;
    logic [AW:0]         level;
    logic [AW:0]         occ;
    logic [ID_WIDTH-1:0] flush_span;
    logic [31:0]         retire_seq;
    logic                capture;
    logic                accept;
    logic                hs;
    logic                done;
    logic                load;
    logic [NUM_STAGES-1:0] mask_rest;
    logic [7:0]          sel_idx;
    logic [ID_WIDTH-1:0] sel_id;
    logic [2:0]          rec_type;
    logic [7:0]          rec_stage;
    logic [ID_WIDTH-1:0] rec_id;
    logic [31:0]         rec_aux;
`ifdef KANATA_TRACER_CYCLE_REC_EN
    logic [31:0]         cycle_cnt;
    logic [31:0]         last_stamp;
`endif

    // Successor chain shared by the running snapshot and the one being loaded.
    function automatic state_t after_retire(input logic [FCW-1:0] cnt);
        return (cnt != '0) ? S_FLUSH : S_IDLE;
    endfunction

    function automatic state_t after_stage(input logic ret, input logic [FCW-1:0] cnt);
        return ret ? S_RETIRE : after_retire(cnt);
    endfunction

    function automatic state_t after_cycle(input logic [NUM_STAGES-1:0] ack, input logic ret,
                                           input logic [FCW-1:0] cnt);
        return (|ack) ? S_STAGE : after_stage(ret, cnt);
    endfunction

    assign capture = trace_en && ((|stage_ack) || retire_ack || flush_valid);
    // The working register holds a slot too, so total buffering is DEPTH snapshots.
    assign occ     = level + (AW+1)'(state != S_IDLE);
    assign accept  = (occ < FULL_LVL) || done;

    always_comb begin
        flush_span      = flush_hi_id - flush_lo_id;
        cap             = '0;
        cap.ack         = stage_ack;
        cap.ids         = stage_id;
        cap.retire      = retire_ack;
        cap.retire_id   = retire_id;
        cap.retire_seq  = retire_seq;
        cap.flush_first = flush_lo_id + ID_WIDTH'(1);
        if (!flush_valid || flush_span <= ID_WIDTH'(1))
            cap.flush_cnt = '0;
        else if (flush_span - ID_WIDTH'(1) > ID_WIDTH'(MAX_FLUSH))
            cap.flush_cnt = FCW'(MAX_FLUSH);
        else
            cap.flush_cnt = FCW'(flush_span - ID_WIDTH'(1));
`ifdef KANATA_TRACER_CYCLE_REC_EN
        cap.stamp = cycle_cnt;
`endif
    end

    kanata_snap_fifo #(
        .WIDTH ($bits(snap_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (capture && accept),
        .push_dat (cap),
        .pop_vld  (head_vld),
        .pop_rdy  (load),
        .pop_dat  (head_dat),
        .level    (level)
    );

    assign head = snap_t'(head_dat);

    always_comb begin
        sel_idx = '0;
        sel_id  = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (work.ack[i]) begin
                sel_idx = 8'(i);
                sel_id  = work.ids[i*ID_WIDTH +: ID_WIDTH];
            end
        end
    end

    always_comb begin
        rec_type  = '0;
        rec_stage = '0;
        rec_id    = '0;
        rec_aux   = '0;
        adv_state = state;
        mask_rest = work.ack & (work.ack - NUM_STAGES'(1));
`ifdef KANATA_TRACER_CYCLE_REC_EN
        head_first = S_CYCLE;
`else
        head_first = after_cycle(head.ack, head.retire, head.flush_cnt);
`endif
        case (state)
            S_STAGE: begin
                rec_type  = 3'd0;
                rec_stage = sel_idx;
                rec_id    = sel_id;
                adv_state = (mask_rest == '0) ? after_stage(work.retire, work.flush_cnt) : S_STAGE;
            end
            S_RETIRE: begin
                rec_type  = 3'd1;
                rec_id    = work.retire_id;
                rec_aux   = work.retire_seq;
                adv_state = after_retire(work.flush_cnt);
            end
            S_FLUSH: begin
                rec_type  = 3'd2;
                rec_id    = work.flush_first;
                adv_state = (work.flush_cnt == FCW'(1)) ? S_IDLE : S_FLUSH;
            end
`ifdef KANATA_TRACER_CYCLE_REC_EN
            S_CYCLE: begin
                rec_type  = 3'd3;
                rec_aux   = work.stamp - last_stamp;
                adv_state = after_cycle(work.ack, work.retire, work.flush_cnt);
            end
`endif
            default: adv_state = S_IDLE;
        endcase

        m_tvalid = (state != S_IDLE);
        m_tdata  = {rec_aux, rec_id, rec_stage, rec_type};
        hs       = m_tvalid && m_tready;
        done     = hs && (adv_state == S_IDLE);
        load     = head_vld && ((state == S_IDLE) || done);
        if (load)
            next_state = head_first;
        else if (hs)
            next_state = adv_state;
        else
            next_state = state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work       <= '0;
            retire_seq <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (load) begin
                work <= head;
            end else if (hs) begin
                if (state == S_STAGE) work.ack <= mask_rest;
                if (state == S_FLUSH) begin
                    work.flush_first <= work.flush_first + ID_WIDTH'(1);
                    work.flush_cnt   <= work.flush_cnt - FCW'(1);
                end
            end
            // Numbering follows the core, so dropped retires still consume a sequence value.
            if (capture && retire_ack) retire_seq <= retire_seq + 32'd1;
            if (capture && !accept) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

`ifdef KANATA_TRACER_CYCLE_REC_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt  <= '0;
            last_stamp <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (hs && state == S_CYCLE) last_stamp <= work.stamp;
        end
    end
`endif
endmodule

// File: tb/tb_kanata_event_tracer.sv
// Directed bench for kanata_event_tracer (default build): latency, ordering, flush clamping, stall/drop, reset.
module tb_kanata_event_tracer;
    localparam int NS = 7;
    localparam int IW = 64;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            trace_en = 1'b0;
    logic [NS-1:0]   stage_ack = '0;
    logic [NS*IW-1:0] stage_id = '0;
    logic            retire_ack = 1'b0;
    logic [IW-1:0]   retire_id = '0;
    logic            flush_valid = 1'b0;
    logic [IW-1:0]   flush_lo_id = '0;
    logic [IW-1:0]   flush_hi_id = '0;
    logic            m_tvalid;
    logic            m_tready = 1'b1;
    logic [106:0]    m_tdata;
    logic            overflow;
    logic [15:0]     drop_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    kanata_event_tracer dut (
        .clk         (clk),
        .rst         (rst),
        .trace_en    (trace_en),
        .stage_ack   (stage_ack),
        .stage_id    (stage_id),
        .retire_ack  (retire_ack),
        .retire_id   (retire_id),
        .flush_valid (flush_valid),
        .flush_lo_id (flush_lo_id),
        .flush_hi_id (flush_hi_id),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tdata     (m_tdata),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {valid, record} so one compare covers both the strobe and the payload.
    function automatic logic [127:0] beat();
        return {20'd0, m_tvalid, m_tdata};
    endfunction

    function automatic logic [127:0] vrec(input logic [2:0] t, input logic [7:0] s,
                                          input logic [63:0] id, input logic [31:0] aux);
        return {20'd0, 1'b1, aux, id, s, t};
    endfunction

    task automatic take(input string tag, input logic [127:0] exp);
        for (int n = 0; n < 10 && !m_tvalid; n++) step();
        check(tag, beat(), exp);
        step();
    endtask

    task automatic flush_once(input logic [63:0] lo, input logic [63:0] hi);
        flush_valid = 1'b1;
        flush_lo_id = lo;
        flush_hi_id = hi;
        step();
        flush_valid = 1'b0;
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_beat", beat(), 128'd0);
        check("rst_overflow", overflow, 0);
        check("rst_drop", drop_cnt, 0);
        step();
        rst = 1'b0;
        trace_en = 1'b1;
        step();

        // Two stage acks in one cycle: first record two cycles later, ascending stage order.
        stage_ack = 7'b0000101;
        stage_id[0*IW +: IW] = 64'd10;
        stage_id[2*IW +: IW] = 64'd12;
        step();
        stage_ack = '0;
        check("lat_t1", beat(), 128'd0);
        step();
        check("lat_t2", beat(), vrec(3'd0, 8'd0, 64'd10, 32'd0));
        step();
        check("stage2", beat(), vrec(3'd0, 8'd2, 64'd12, 32'd0));
        step();
        check("stage_end", beat(), 128'd0);

        // Three consecutive retires drain back to back with sequence 0,1,2.
        retire_ack = 1'b1;
        retire_id = 64'd5;
        step();
        retire_id = 64'd6;
        step();
        check("ret0", beat(), vrec(3'd1, 8'd0, 64'd5, 32'd0));
        retire_id = 64'd7;
        step();
        check("ret1", beat(), vrec(3'd1, 8'd0, 64'd6, 32'd1));
        retire_ack = 1'b0;
        step();
        check("ret2", beat(), vrec(3'd1, 8'd0, 64'd7, 32'd2));
        step();
        check("ret_end", beat(), 128'd0);

        flush_once(64'd20, 64'd24);
        for (int k = 0; k < 3; k++)
            take($sformatf("fl24_%0d", k), vrec(3'd2, 8'd0, 64'(21 + k), 32'd0));
        check("fl24_end", beat(), 128'd0);

        flush_once(64'd20, 64'd21);
        repeat (4) step();
        check("fl21_none", beat(), 128'd0);

        flush_once(64'd0, 64'd100);
        for (int k = 0; k < 16; k++)
            take($sformatf("fl100_%0d", k), vrec(3'd2, 8'd0, 64'(1 + k), 32'd0));
        check("fl100_clamp", beat(), 128'd0);

        // Kill range wrapping through zero.
        flush_once(64'hFFFF_FFFF_FFFF_FFFE, 64'd1);
        take("flwrap_0", vrec(3'd2, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'd0));
        take("flwrap_1", vrec(3'd2, 8'd0, 64'd0, 32'd0));
        check("flwrap_end", beat(), 128'd0);

        // Disabled capture: nothing recorded, sequence untouched.
        trace_en = 1'b0;
        retire_ack = 1'b1;
        retire_id = 64'd77;
        stage_ack = 7'b0000001;
        step();
        retire_ack = 1'b0;
        stage_ack = '0;
        repeat (4) step();
        check("en_off", beat(), 128'd0);
        trace_en = 1'b1;

        // Mixed snapshot: stages, then retire (seq 3), then flush.
        stage_ack = 7'b1000010;
        stage_id[1*IW +: IW] = 64'd41;
        stage_id[6*IW +: IW] = 64'd46;
        retire_ack = 1'b1;
        retire_id = 64'd9;
        flush_once(64'd30, 64'd32);
        stage_ack = '0;
        retire_ack = 1'b0;
        take("mix_s1", vrec(3'd0, 8'd1, 64'd41, 32'd0));
        take("mix_s6", vrec(3'd0, 8'd6, 64'd46, 32'd0));
        take("mix_ret", vrec(3'd1, 8'd0, 64'd9, 32'd3));
        take("mix_fl", vrec(3'd2, 8'd0, 64'd31, 32'd0));
        check("mix_end", beat(), 128'd0);

        // Stall with a stage ack every cycle: DEPTH snapshots kept, the rest dropped.
        m_tready = 1'b0;
        for (int k = 0; k < 40; k++) begin
            stage_ack = 7'b0000001;
            stage_id[0*IW +: IW] = 64'(100 + k);
            step();
            if (k == 5) check("stall_hold_a", beat(), vrec(3'd0, 8'd0, 64'd100, 32'd0));
        end
        stage_ack = '0;
        repeat (3) step();
        check("stall_hold_b", beat(), vrec(3'd0, 8'd0, 64'd100, 32'd0));
        check("ovf_set", overflow, 1);
        check("drop_32", drop_cnt, 32);
        m_tready = 1'b1;
        for (int k = 0; k < 8; k++)
            take($sformatf("drain_%0d", k), vrec(3'd0, 8'd0, 64'(100 + k), 32'd0));
        check("drain_end", beat(), 128'd0);
        check("ovf_sticky", overflow, 1);

        // Reset mid-record discards everything immediately.
        stage_ack = 7'b0000111;
        stage_id[0*IW +: IW] = 64'd1;
        stage_id[1*IW +: IW] = 64'd2;
        stage_id[2*IW +: IW] = 64'd3;
        step();
        stage_ack = '0;
        take("pre_rst", vrec(3'd0, 8'd0, 64'd1, 32'd0));
        #2 rst = 1'b1;
        #1;
        check("mid_rst_beat", beat(), 128'd0);
        check("mid_rst_drop", drop_cnt, 0);
        check("mid_rst_ovf", overflow, 0);
        step();
        rst = 1'b0;
        step();
        check("post_rst_idle", beat(), 128'd0);
        retire_ack = 1'b1;
        retire_id = 64'd55;
        step();
        retire_ack = 1'b0;
        take("post_rst_ret", vrec(3'd1, 8'd0, 64'd55, 32'd0));
        check("post_rst_end", beat(), 128'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
